fnd_display_scheduler: RTL and testbench
========================================

Name: fnd_display_scheduler

Overview:
- Shares one 4-digit FND display controller between two value sources (A, B).
- Drives the controller's 14-bit value bus and its 2-bit control bus:
  - bit1 = digit-select/display enable.
  - bit0 = data-register latch enable.
- Round-robin arbitration with a guaranteed minimum display time per grant and optional blinking.
- Sits between application sources (e.g. clock, stopwatch) and the FND controller.

Parameters:
TICK_DIV, 100000, clock cycles per display tick (1 ms at 100 MHz)
HOLD_TICKS, 1000, minimum ticks a granted value stays shown
BLINK_TICKS, 250, ticks per blink half-period
MAX_VALUE, 9999, saturation limit for displayed value

Ports:
i_clk  input  1  system clock, rising edge
i_reset  input  1  asynchronous, active-low reset
i_req_a  input  1  source A requests display, level
i_value_a  input  14  source A value
i_req_b  input  1  source B requests display, level
i_value_b  input  14  source B value
i_blink  input  1  1 = blink display while showing
o_value  output  14  value to FND controller
o_control  output  2  [1] display enable, [0] latch enable
o_grant_a  output  1  A owns display
o_grant_b  output  1  B owns display
o_busy  output  1  state != IDLE

Behaviour:
- **Reset (i_reset=0, async):**
  - State IDLE; o_value=0, o_control=2'b00, o_grant_a=o_grant_b=0, o_busy=0.
  - last_grant=B, so A wins the first tie.
  - Prescaler, hold counter and blink counter = 0; blink phase = 1.
- **All outputs registered.**
- **Prescaler:**
  - Counts 0..TICK_DIV-1; tick = one-cycle pulse when the count is TICK_DIV-1, then wraps to 0.
  - Cleared in the LATCH state, so SHOW timing is exact.
- **Arbitration (IDLE, and at hold expiry):**
  - Only one request asserted: that source wins.
  - Both asserted: the source not equal to last_grant wins.
  - No request: no winner.
- **FSM states: IDLE, LATCH, SHOW.**
- **IDLE:**
  - o_control=00; o_value holds the last latched value; grants 0.
  - Winner found -> LATCH on the next edge.
- **LATCH (exactly 1 cycle):**
  - o_value = min(winner value, MAX_VALUE); o_control=11.
  - Winner's grant=1, other grant=0; last_grant=winner.
  - Hold counter, prescaler and blink counter cleared; blink phase=1.
  - -> SHOW.
- **SHOW:**
  - o_control[0]=0; o_value frozen; grant held.
  - o_control[1] = 1 if i_blink=0, else blink phase.
  - Hold counter increments on each tick.
  - Blink counter increments on each tick; at BLINK_TICKS it toggles the phase and clears.
- **Hold expiry:** hold counter reaches HOLD_TICKS, i.e. exactly HOLD_TICKS*TICK_DIV cycles in SHOW. Arbitration is evaluated on the requests present in that cycle:
  - Winner -> LATCH. This also covers the same source re-winning, which refreshes its value.
  - No winner -> IDLE; grants drop on entry to IDLE.
- **Request deassert before expiry:** ignored; the display is held until expiry (minimum display time).
- **Grants:** always one-hot or zero; a grant changes only on a LATCH cycle or on entry to IDLE.
- **Blink phase:** i_blink toggling mid-SHOW takes effect on the next cycle; the phase counter keeps running regardless.
- **Saturation:** values 10000..16383 display as 9999; values <=9999 pass unchanged.
- **Counter widths:** clog2(param+1); no overflow, since each counter clears at its limit.
- **Reset mid-operation:** immediate return to reset values; no latch pulse is emitted.

Test Plan:
All scenarios use TICK_DIV=4, HOLD_TICKS=3, BLINK_TICKS=2.

1. Reset then idle, no requests -> o_control=00, o_value=0, grants 0, o_busy=0 for 50 cycles.
2. A requests, value 1234, held 1 cycle then dropped:
   - LATCH the cycle after the request: o_control=11, o_value=1234, o_grant_a=1.
   - Then o_control=10 for exactly 12 cycles.
   - Then IDLE with o_control=00 and o_value still 1234.
3. A and B request simultaneously and continuously (A=1111, B=2222) -> grants alternate A, B, A, ...; each LATCH cycle is followed by 12 SHOW cycles, and o_value follows the granted source.
4. Only A requests continuously, value changing 5 -> 6 during SHOW -> o_value stays 5 until the refresh LATCH after 12 cycles, then 6.
5. A requests with value 16383 -> o_value=9999; value 9999 -> 9999; value 0 -> 0.
6. Blink and reset:
   - i_blink=1 in SHOW -> o_control[1] toggles every 8 cycles, starting at 1.
   - i_reset=0 mid-SHOW -> all outputs 0 asynchronously; IDLE after release.

Source files
------------

// File: rtl/fnd_display_scheduler_if.sv
// Source-to-scheduler bundle: two value requesters, blink control,
// and the registered FND controller drive returned by the scheduler.
interface fnd_display_scheduler_if;
  logic        i_req_a;
  logic [13:0] i_value_a;
  logic        i_req_b;
  logic [13:0] i_value_b;
  logic        i_blink;
  logic [13:0] o_value;
  logic [1:0]  o_control;
  logic        o_grant_a;
  logic        o_grant_b;
  logic        o_busy;

  modport master (
    output i_req_a, i_value_a,
    output i_req_b, i_value_b,
    output i_blink,
    input  o_value, o_control,
    input  o_grant_a, o_grant_b,
    input  o_busy
  );

  modport slave (
    input  i_req_a, i_value_a,
    input  i_req_b, i_value_b,
    input  i_blink,
    output o_value, o_control,
    output o_grant_a, o_grant_b,
    output o_busy
  );
endinterface

// File: rtl/fnd_display_scheduler.sv
// Round-robin owner of a shared 4-digit FND controller with a
// guaranteed minimum display time and optional blinking.
module fnd_display_scheduler #(
  parameter int TICK_DIV    = 100000,
  parameter int HOLD_TICKS  = 1000,
  parameter int BLINK_TICKS = 250,
  parameter int MAX_VALUE   = 9999
) (
  input logic                    i_clk,
  input logic                    i_reset,
  fnd_display_scheduler_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [13:0]   MAX_V  = 14'(MAX_VALUE);

  typedef enum logic [1:0] {IDLE, LATCH, SHOW} state_t;

  state_t        state, state_d;
  logic [PW-1:0] presc;
  logic [HW-1:0] hold;
  logic [BW-1:0] blink;
  logic          phase, phase_d;
  logic          last_b;
  logic [13:0]   value, value_d;
  logic [1:0]    ctrl, ctrl_d;
  logic          grant_a, grant_a_d;
  logic          grant_b, grant_b_d;
  logic          busy;
  logic          tick, expire;
  logic          win_a, win_b;

  function automatic logic [13:0] sat(
    input logic [13:0] v
  );
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  assign tick   = presc == P_LAST;
  assign expire = state == SHOW && tick
               && hold == H_LAST;

  // On a tie the source that did not win last time takes it.
  assign win_a = bus.i_req_a
               & (~bus.i_req_b | last_b);
  assign win_b = bus.i_req_b
               & (~bus.i_req_a | ~last_b);

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:
        if (win_a | win_b)
          state_d = LATCH;
      LATCH:
        state_d = SHOW;
      SHOW:
        if (expire)
          state_d = (win_a | win_b)
                  ? LATCH : IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    phase_d = phase;
    if (state == LATCH)
      phase_d = 1'b1;
    else if (state == SHOW && tick
             && blink == B_LAST)
      phase_d = ~phase;
  end

  // Outputs are registered from the state being entered.
  always_comb begin
    value_d   = value;
    ctrl_d    = 2'b00;
    grant_a_d = grant_a;
    grant_b_d = grant_b;
    unique case (state_d)
      LATCH: begin
        value_d   = sat(win_a ? bus.i_value_a
                              : bus.i_value_b);
        ctrl_d    = 2'b11;
        grant_a_d = win_a;
        grant_b_d = win_b;
      end
      SHOW:
        ctrl_d = {~bus.i_blink | phase_d, 1'b0};
      default: begin
        grant_a_d = 1'b0;
        grant_b_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)
      state <= IDLE;
    else
      state <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      presc   <= '0;
      hold    <= '0;
      blink   <= '0;
      phase   <= 1'b1;
      last_b  <= 1'b1;
      value   <= '0;
      ctrl    <= 2'b00;
      grant_a <= 1'b0;
      grant_b <= 1'b0;
      busy    <= 1'b0;
    end else begin
      phase   <= phase_d;
      value   <= value_d;
      ctrl    <= ctrl_d;
      grant_a <= grant_a_d;
      grant_b <= grant_b_d;
      busy    <= state_d != IDLE;
      if (state_d == LATCH)
        last_b <= win_b;
      if (state == LATCH) begin
        presc <= '0;
        hold  <= '0;
        blink <= '0;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (state == SHOW && tick) begin
          hold  <= expire ? '0 : hold + 1'b1;
          blink <= (blink == B_LAST)
                 ? '0 : blink + 1'b1;
        end
      end
    end
  end

  assign bus.o_value   = value;
  assign bus.o_control = ctrl;
  assign bus.o_grant_a = grant_a;
  assign bus.o_grant_b = grant_b;
  assign bus.o_busy    = busy;
endmodule

// File: tb/tb_fnd_display_scheduler.sv
// Scoreboard bench: a transaction-level model predicts each cycle's
// outputs into a queue; a negedge monitor pops and compares.
module tb_fnd_display_scheduler;
  localparam int TICK_DIV    = 4;
  localparam int HOLD_TICKS  = 3;
  localparam int BLINK_TICKS = 2;
  localparam int MAX_VALUE   = 9999;
  localparam int SHOW_LEN    = HOLD_TICKS * TICK_DIV;
  localparam int HALF        = BLINK_TICKS * TICK_DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [18:0] q[$];
  logic [18:0] dut_out;

  int   m_mode;
  int   m_k;
  int   m_last;
  int   m_owner;
  int   m_val;
  int   m_w;
  logic m_ph;
  logic [1:0] m_ctl;

  logic ra, rb, bl;
  int   sat_vals[3] = '{16383, 9999, 0};

  fnd_display_scheduler_if bus();

  fnd_display_scheduler #(
    .TICK_DIV   (TICK_DIV),
    .HOLD_TICKS (HOLD_TICKS),
    .BLINK_TICKS(BLINK_TICKS),
    .MAX_VALUE  (MAX_VALUE)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  assign dut_out = {bus.o_value, bus.o_control,
                    bus.o_grant_a, bus.o_grant_b,
                    bus.o_busy};

  function automatic int sat(input int v);
    return (v > MAX_VALUE) ? MAX_VALUE : v;
  endfunction

  task automatic check(input string tag,
                       input logic [18:0] got,
                       input logic [18:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got val=%0d ctl=%b ga=%b gb=%b busy=%b want val=%0d ctl=%b ga=%b gb=%b busy=%b",
               tag, $time, got[18:5], got[4:3], got[2],
               got[1], got[0], exp[18:5], exp[4:3],
               exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic a, input int va,
                       input logic b, input int vb,
                       input logic blk);
    bus.i_req_a   = a;
    bus.i_value_a = 14'(va);
    bus.i_req_b   = b;
    bus.i_value_b = 14'(vb);
    bus.i_blink   = blk;
  endtask

  // Model: 0 = idle, 1 = latch, 2 = showing for m_k cycles.
  initial begin
    m_mode = 0; m_k = 0; m_last = 1;
    m_owner = -1; m_val = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = 0; m_k = 0; m_last = 1;
        m_owner = -1; m_val = 0;
        q.delete();
      end else begin
        if (m_mode == 0 ||
            (m_mode == 2 && m_k == SHOW_LEN)) begin
          m_w = -1;
          if (bus.i_req_a && bus.i_req_b)
            m_w = (m_last == 0) ? 1 : 0;
          else if (bus.i_req_a)
            m_w = 0;
          else if (bus.i_req_b)
            m_w = 1;
          if (m_w >= 0) begin
            m_mode  = 1;
            m_owner = m_w;
            m_last  = m_w;
            m_val   = sat((m_w == 0)
                      ? int'(bus.i_value_a)
                      : int'(bus.i_value_b));
          end else begin
            m_mode  = 0;
            m_owner = -1;
          end
        end else if (m_mode == 1) begin
          m_mode = 2;
          m_k    = 1;
        end else begin
          m_k++;
        end
        m_ph = bus.i_blink
             ? (((m_k - 1) / HALF) % 2 == 0) : 1'b1;
        if (m_mode == 0)      m_ctl = 2'b00;
        else if (m_mode == 1) m_ctl = 2'b11;
        else                  m_ctl = {m_ph, 1'b0};
        q.push_back({14'(m_val), m_ctl,
                     m_owner == 0, m_owner == 1,
                     m_mode != 0});
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n)
        check("reset", dut_out, '0);
      else if (q.size() > 0)
        check("cycle", dut_out, q.pop_front());
    end
  end

  initial begin
    drive(0, 0, 0, 0, 0);
    cyc(3);
    #1 rst_n = 1'b1;
    cyc(50);

    drive(1, 1234, 0, 0, 0);
    cyc(1);
    drive(0, 1234, 0, 0, 0);
    cyc(20);

    drive(1, 1111, 1, 2222, 0);
    cyc(60);
    drive(0, 0, 0, 0, 0);
    cyc(16);

    drive(1, 5, 0, 0, 0);
    cyc(6);
    drive(1, 6, 0, 0, 0);
    cyc(20);
    drive(0, 0, 0, 0, 0);
    cyc(16);

    foreach (sat_vals[i]) begin
      drive(1, sat_vals[i], 0, 0, 0);
      cyc(1);
      drive(0, 0, 0, 0, 0);
      cyc(15);
    end

    drive(1, 777, 0, 0, 1);
    cyc(1);
    drive(0, 777, 0, 0, 1);
    cyc(16);
    drive(0, 0, 0, 0, 0);

    drive(0, 0, 1, 4321, 0);
    cyc(1);
    drive(0, 0, 0, 0, 0);
    cyc(5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", dut_out, '0);
    cyc(3);
    #1 rst_n = 1'b1;
    cyc(10);

    ra = 1'b0; rb = 1'b0; bl = 1'b0;
    repeat (500) begin
      if ($urandom_range(0, 7) == 0) ra = ~ra;
      if ($urandom_range(0, 7) == 0) rb = ~rb;
      if ($urandom_range(0, 15) == 0) bl = ~bl;
      drive(ra, int'($urandom_range(0, 16383)),
            rb, int'($urandom_range(0, 16383)), bl);
      cyc(1);
    end
    drive(0, 0, 0, 0, 0);
    cyc(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
